vec_elem_seq: RTL

VEC_ELEM_SEQ -- requirements
Module: vec_elem_seq

---
 rtl/vec_elem_seq.sv | 129 ++++++++++++
 1 files changed

// File: rtl/vec_elem_seq.sv
// vec_elem_seq: expands one vector op {opc, vd, vs1, vs2, vl} into a stream
// of per-element micro-ops {opc, vd, vs1, vs2, idx, last}, one per cycle.
// Vector lengths above NUM_ELEMS are clamped; vl==0 ops are consumed silently.
// Optional feature macro: VEC_ELEM_SEQ_PIPE_EN. It accepts the next op in the
// cycle the current op's last micro-op leaves, so there is no idle bubble.
module vec_elem_seq #(
    parameter int NUM_ELEMS = 8,
    parameter int OPC_W     = 4,
    parameter int REG_W     = 5,
    localparam int IDX_W    = $clog2(NUM_ELEMS),
    localparam int VL_W     = IDX_W + 1,
    localparam int IN_W     = OPC_W + 3*REG_W + VL_W,
    localparam int OUT_W    = OPC_W + 3*REG_W + IDX_W + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [IN_W-1:0]  recv_msg,
    input  logic             recv_val,
    output logic             recv_rdy,
    output logic [OUT_W-1:0] send_msg,
    output logic             send_val,
    input  logic             send_rdy,
    output logic             busy
);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_ISSUE = 1'b1
    } state_t;

    localparam logic [VL_W-1:0] MAX_VL = VL_W'(NUM_ELEMS);

    state_t             r_state;
    state_t             w_next_state;
    logic [OPC_W-1:0]   r_opc;
    logic [REG_W-1:0]   r_vd;
    logic [REG_W-1:0]   r_vs1;
    logic [REG_W-1:0]   r_vs2;
    logic [IDX_W-1:0]   r_idx;
    logic [VL_W-1:0]    r_eff_vl;

    logic [OPC_W-1:0]   w_opc;
    logic [REG_W-1:0]   w_vd;
    logic [REG_W-1:0]   w_vs1;
    logic [REG_W-1:0]   w_vs2;
    logic [VL_W-1:0]    w_vl;
    logic [VL_W-1:0]    w_eff_vl;
    logic               w_last;
    logic               w_load;
    logic               w_adv;

    // Unpack the incoming op and clamp its length to the vector size.
    always_comb begin
        w_vl     = recv_msg[VL_W-1:0];
        w_vs2    = recv_msg[VL_W +: REG_W];
        w_vs1    = recv_msg[VL_W+REG_W +: REG_W];
        w_vd     = recv_msg[VL_W+2*REG_W +: REG_W];
        w_opc    = recv_msg[VL_W+3*REG_W +: OPC_W];
        w_eff_vl = (w_vl > MAX_VL) ? MAX_VL : w_vl;
        w_last   = ({1'b0, r_idx} == (r_eff_vl - 1'b1));
        send_msg = {r_opc, r_vd, r_vs1, r_vs2, r_idx, w_last};
    end

    // Next-state, handshake outputs and datapath load/advance strobes.
    always_comb begin
        w_next_state = r_state;
        recv_rdy     = 1'b0;
        send_val     = 1'b0;
        busy         = 1'b0;
        w_load       = 1'b0;
        w_adv        = 1'b0;
        case (r_state)
            S_IDLE: begin
                recv_rdy = 1'b1;
                if (recv_val && (w_vl != '0)) begin
                    w_load       = 1'b1;
                    w_next_state = S_ISSUE;
                end
            end
            S_ISSUE: begin
                send_val = 1'b1;
                busy     = 1'b1;
                if (send_rdy) begin
                    if (!w_last) begin
                        w_adv = 1'b1;
                    end else begin
                        w_next_state = S_IDLE;
`ifdef VEC_ELEM_SEQ_PIPE_EN
                        // Last element leaving: the next op may be taken in
                        // the same cycle and issue from idx 0 immediately.
                        recv_rdy = 1'b1;
                        if (recv_val && (w_vl != '0)) begin
                            w_load       = 1'b1;
                            w_next_state = S_ISSUE;
                        end
`endif
                    end
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // State register and op/index datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_opc    <= '0;
            r_vd     <= '0;
            r_vs1    <= '0;
            r_vs2    <= '0;
            r_idx    <= '0;
            r_eff_vl <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_load) begin
                r_opc    <= w_opc;
                r_vd     <= w_vd;
                r_vs1    <= w_vs1;
                r_vs2    <= w_vs2;
                r_eff_vl <= w_eff_vl;
                r_idx    <= '0;
            end else if (w_adv) begin
                r_idx <= r_idx + 1'b1;
            end
        end
    end

endmodule
